// File: rtl/rca_nibble_serial_adder_if.sv
// Request/response bundle for the nibble-serial adder controller.
// The master issues operand pairs and consumes results.
interface rca_nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;

  modport master (
    output in_valid, op_a, op_b, op_cin, out_ready,
    input  in_ready, out_valid, res_sum, res_carry
  );

  modport slave (
    input  in_valid, op_a, op_b, op_cin, out_ready,
    output in_ready, out_valid, res_sum, res_carry
  );
endinterface

// File: rtl/rca_nibble_serial_adder.sv
// Sequences a WIDTH-bit addition through an external 4-bit ripple-carry adder,
// one nibble per cycle, LSB first, with the carry chained through carry_q.
module rca_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  rca_nibble_serial_adder_if.slave bus,
  output logic [3:0]               add_a,
  output logic [3:0]               add_b,
  output logic                     add_cin,
  input  logic [3:0]               add_sum,
  input  logic                     add_carry,
  output logic                     busy
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;

  logic [IDX_W+1:0] bit_ofs;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;

  // Shifts instead of variable part-selects keep the index width independent of WIDTH.
  assign bit_ofs = {idx_q, 2'b00};
  assign a_sh    = a_q >> bit_ofs;
  assign b_sh    = b_q >> bit_ofs;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    res_d   = res_q & ~(WIDTH'(4'hF) << bit_ofs);
    res_d   = res_d | (WIDTH'(add_sum) << bit_ofs);
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_sh[3:0];
      add_b   = b_sh[3:0];
      add_cin = carry_q;
    end
  end

  // in_ready is masked by rst so every output reads 0 while reset is held.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.res_sum   = (state_q == DONE) ? res_q : '0;
  assign bus.res_carry = (state_q == DONE) && carry_q;
  assign busy          = (state_q != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.op_a;
            b_q     <= bus.op_b;
            carry_q <= bus.op_cin;
            idx_q   <= '0;
            res_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q   <= res_d;
          carry_q <= add_carry;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rca_nibble_serial_adder.sv
// Bench for rca_nibble_serial_adder: directed cases at WIDTH=16, then random
// traffic at WIDTH=16 and WIDTH=4 against an a+b+cin scoreboard.
module tb_rca_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  rca_nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
  rca_nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  logic [3:0] add_a16, add_b16, add_sum16;
  logic       add_cin16, add_carry16, busy16;
  logic [3:0] add_a4, add_b4, add_sum4;
  logic       add_cin4, add_carry4, busy4;

  // Behavioural 4-bit adders standing in for the real datapath.
  assign {add_carry16, add_sum16} = {1'b0, add_a16} + {1'b0, add_b16} + {4'b0, add_cin16};
  assign {add_carry4, add_sum4}   = {1'b0, add_a4} + {1'b0, add_b4} + {4'b0, add_cin4};

  rca_nibble_serial_adder #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .bus(bus16),
    .add_a(add_a16), .add_b(add_b16), .add_cin(add_cin16),
    .add_sum(add_sum16), .add_carry(add_carry16), .busy(busy16)
  );

  rca_nibble_serial_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(bus4),
    .add_a(add_a4), .add_b(add_b4), .add_cin(add_cin4),
    .add_sum(add_sum4), .add_carry(add_carry4), .busy(busy4)
  );

  logic [16:0] sb16[$];
  logic [4:0]  sb4[$];

  logic [15:0] seq_a;
  logic [3:0]  seq_c;
  logic [16:0] res;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept16(input logic [15:0] a, input logic [15:0] b, input logic c);
    check("in_ready_idle", 32'(bus16.in_ready), 32'd1);
    bus16.op_a     = a;
    bus16.op_b     = b;
    bus16.op_cin   = c;
    bus16.in_valid = 1'b1;
    sb16.push_back({1'b0, a} + {1'b0, b} + {16'b0, c});
    @(negedge clk);
    bus16.in_valid = 1'b0;
  endtask

  // One full transaction; hold = cycles out_ready stays low once DONE is reached.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c, input int hold,
                       output logic [15:0] sa, output logic [3:0] sc, output logic [16:0] r);
    logic [16:0] exp;
    accept16(a, b, c);
    for (int k = 0; k < 4; k++) begin
      sa[4*k +: 4] = add_a16;
      sc[k]        = add_cin16;
      check("run_no_valid", 32'(bus16.out_valid), 32'd0);
      check("run_busy", 32'(busy16), 32'd1);
      @(negedge clk);
    end
    check("latency_valid", 32'(bus16.out_valid), 32'd1);
    for (int h = 0; h < hold; h++) begin
      bus16.in_valid = (h == 1);
      bus16.op_a     = 16'hDEAD;
      bus16.op_b     = 16'hBEEF;
      check("hold_valid", 32'(bus16.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus16.in_ready), 32'd0);
      check("hold_result", 32'({bus16.res_carry, bus16.res_sum}), 32'(sb16[0]));
      check("hold_adder_idle", 32'({add_a16, add_b16, add_cin16}), 32'd0);
      @(negedge clk);
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b1;
    r   = {bus16.res_carry, bus16.res_sum};
    exp = sb16.pop_front();
    check("result", 32'(r), 32'(exp));
    @(negedge clk);
    bus16.out_ready = 1'b0;
    check("post_out_valid", 32'(bus16.out_valid), 32'd0);
    check("post_in_ready", 32'(bus16.in_ready), 32'd1);
    check("post_busy", 32'(busy16), 32'd0);
  endtask

  task automatic rand16(input int n);
    int          done = 0;
    int          issued = 0;
    int          cyc = 0;
    logic [16:0] exp;
    while (done < n && cyc < 40000) begin
      bus16.out_ready = ($urandom_range(0, 3) != 0);
      bus16.in_valid  = (issued < n) && ($urandom_range(0, 3) != 0);
      bus16.op_a      = 16'($urandom());
      bus16.op_b      = 16'($urandom());
      bus16.op_cin    = 1'($urandom_range(0, 1));
      if (bus16.out_valid && bus16.out_ready) begin
        check("rnd16_expected", 32'(sb16.size() != 0), 32'd1);
        if (sb16.size() != 0) begin
          exp = sb16.pop_front();
          check("rnd16_result", 32'({bus16.res_carry, bus16.res_sum}), 32'(exp));
        end
        done++;
      end
      if (bus16.in_valid && bus16.in_ready) begin
        sb16.push_back({1'b0, bus16.op_a} + {1'b0, bus16.op_b} + {16'b0, bus16.op_cin});
        issued++;
      end
      cyc++;
      @(negedge clk);
    end
    bus16.in_valid  = 1'b0;
    bus16.out_ready = 1'b0;
    check("rnd16_done", 32'(done), 32'(n));
    check("rnd16_sb_empty", 32'(sb16.size()), 32'd0);
  endtask

  task automatic rand4(input int n);
    int         done = 0;
    int         issued = 0;
    int         cyc = 0;
    logic [4:0] exp;
    while (done < n && cyc < 30000) begin
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      bus4.in_valid  = (issued < n) && ($urandom_range(0, 3) != 0);
      bus4.op_a      = 4'($urandom());
      bus4.op_b      = 4'($urandom());
      bus4.op_cin    = 1'($urandom_range(0, 1));
      if (bus4.out_valid && bus4.out_ready) begin
        check("rnd4_expected", 32'(sb4.size() != 0), 32'd1);
        if (sb4.size() != 0) begin
          exp = sb4.pop_front();
          check("rnd4_result", 32'({bus4.res_carry, bus4.res_sum}), 32'(exp));
        end
        done++;
      end
      if (bus4.in_valid && bus4.in_ready) begin
        sb4.push_back({1'b0, bus4.op_a} + {1'b0, bus4.op_b} + {4'b0, bus4.op_cin});
        issued++;
      end
      cyc++;
      @(negedge clk);
    end
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    check("rnd4_done", 32'(done), 32'(n));
    check("rnd4_sb_empty", 32'(sb4.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, 32'(bus16.in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(bus16.out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy16), 32'd0);
    check({tag, "_adder"}, 32'({add_a16, add_b16, add_cin16}), 32'd0);
    check({tag, "_res"}, 32'({bus16.res_carry, bus16.res_sum}), 32'd0);
    check({tag, "_in_ready4"}, 32'(bus4.in_ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus16.in_valid = 1'b0; bus16.op_a = '0; bus16.op_b = '0; bus16.op_cin = 1'b0; bus16.out_ready = 1'b0;
    bus4.in_valid  = 1'b0; bus4.op_a  = '0; bus4.op_b  = '0; bus4.op_cin  = 1'b0; bus4.out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(bus16.in_ready), 32'd1);
    check("idle_busy", 32'(busy16), 32'd0);

    run16(16'h1234, 16'h4321, 1'b0, 0, seq_a, seq_c, res);
    check("t1_sum", 32'(res), 32'h05555);
    check("t1_add_a_seq", 32'(seq_a), 32'h1234);

    run16(16'hFFFF, 16'h0001, 1'b0, 0, seq_a, seq_c, res);
    check("t2_sum", 32'(res), 32'h10000);
    check("t2_add_cin_seq", 32'(seq_c), 32'(4'b1110));

    run16(16'hFFFF, 16'hFFFF, 1'b1, 0, seq_a, seq_c, res);
    check("t3_sum", 32'(res), 32'h1FFFF);

    run16(16'h1111, 16'h2222, 1'b0, 5, seq_a, seq_c, res);
    check("t4_sum", 32'(res), 32'h03333);

    // Abort a transaction mid-flight at idx==2.
    accept16(16'hAAAA, 16'h5555, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    void'(sb16.pop_back());
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("after_rst_no_valid", 32'(bus16.out_valid), 32'd0);
    end
    run16(16'h0F0F, 16'h00F1, 1'b0, 0, seq_a, seq_c, res);
    check("t5_sum", 32'(res), 32'h01000);

    rand16(1000);
    rand4(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
